hazard_scoreboard: RTL
======================

# hazard_scoreboard

Parametrised successor to the fixed 5-stage hazard detector. It tracks every in-flight destination register in a configurable-depth slot pipeline, with per-class result latency (ALU vs load). Each cycle it decides whether the instruction in ID must stall, or from which downstream stage each source operand is forwarded. It also supports whole-pipe memory wait states and counts data-hazard stall cycles. It sits beside the ID stage and drives the stall/PC control and the operand forwarding muxes.

## Interface
- NREG, 32: architectural register count; RW = $clog2(NREG)
- PIPE_DEPTH, 3: tracked stages after ID (slot 1 = EX … slot PIPE_DEPTH = WB); FW = $clog2(PIPE_DEPTH+1)
- ALU_READY, 1: lowest slot index whose ALU result is forwardable
- LOAD_READY, 2: lowest slot index whose load data is forwardable; must satisfy ALU_READY ≤ LOAD_READY ≤ PIPE_DEPTH
- CNT_W, 16: width of the hazard stall counter
- clk  in  1  clock; all state updates on posedge
- rst_n  in  1  synchronous active-low reset
- issue_valid  in  1  ID holds a real instruction
- issue_rd  in  RW  destination of the ID instruction (0 = none)
- issue_is_load  in  1  ID instruction is a load
- issue_rs1, issue_rs2  in  RW  source registers
- use_rs1, use_rs2  in  1  the corresponding source is actually read
- flush  in  1  discard the ID instruction (branch/jump redirect)
- mem_stall  in  1  memory wait state; freeze the whole pipeline
- stall  out  1  hold IF/ID this cycle
- fwd_rs1, fwd_rs2  out  FW  operand source: 0 = register file, k = slot k
- hazard_cnt  out  CNT_W  saturating count of data-hazard stall cycles

## Operation
- Slot k holds {valid, rd, is_load}. A slot matches source r iff valid, rd == r, r != 0, and the matching use_rsX is high.
- Per source, the youngest matching slot (smallest k) is selected. fwd_rsX = k if k ≥ READY(is_load of that slot), else 0.
- No match, or use_rsX low: fwd_rsX = 0. Older matches behind a younger one are ignored.
- data_hazard = issue_valid & !flush & (the youngest match for rs1 or rs2 has k < its READY).
- stall = mem_stall | data_hazard.
- Advance (mem_stall = 0): slot[k+1] ← slot[k] and slot[PIPE_DEPTH] retires.
  - slot[1] ← {1, issue_rd, issue_is_load} if issue_valid & !flush & !data_hazard.
  - Otherwise slot[1] ← bubble (valid 0).
- Hold (mem_stall = 1): no slot changes. flush has no effect; the controller keeps flush asserted until mem_stall drops.
- hazard_cnt increments on each cycle with data_hazard & !mem_stall, saturating at all-ones.
- Priority: reset > mem_stall > flush > data_hazard.

## Timing
- stall, fwd_rs1 and fwd_rs2 are combinational from the issue inputs, mem_stall and slot state; they are valid in the same cycle.
- Slots and hazard_cnt are registered; an accepted issue is visible in slot 1 on the next cycle.
- Load-use penalty is LOAD_READY − 1 cycles. ALU-use penalty is ALU_READY − 1 cycles, which is 0 at the default.
- Reset (rst_n low at posedge): all slots invalid, hazard_cnt = 0. Outputs then settle to stall = mem_stall, fwd_rs1 = fwd_rs2 = 0.
- Reset mid-operation discards all in-flight entries; no stale forwards after reset.
- When rd matches in several slots, the youngest always wins. A bubble never matches.

## Structure
- Package hazard_pkg holds:
  - slot typedef {valid, rd, is_load}
  - FWD_RF = 0 encoding
  - parameter legality check (elaboration-time assertion on the READY ordering)
- Sub-module hazard_slot_pipe: the PIPE_DEPTH-entry shift register with advance/hold/bubble-insert.
- Top level holds the match/priority logic, the stall/fwd decode and the counter.

## Test plan
All scenarios use default parameters.
- ALU writes x5, next cycle an add reads rs1 = x5 → stall 0, fwd_rs1 = 1; the cycle after, a consumer reads x5 → fwd = 2.
- Load x6, next instruction reads rs2 = x6 → stall 1 for one cycle, bubble in slot 1, hazard_cnt = 1; next cycle stall 0, fwd_rs2 = 2.
- Load x0, next instruction reads x0 → stall 0, fwd 0, hazard_cnt unchanged.
- x7 written by slot 2 (ALU) and slot 1 (ALU), consumer reads x7 on both sources → fwd_rs1 = fwd_rs2 = 1.
- Load x8 in slot 1, dependent in ID, mem_stall high 3 cycles → stall high for 4 cycles total, slots frozen during the 3 cycles, hazard_cnt +1 only; then fwd = 2.
- Load in flight, flush with a dependent in ID → stall 0, bubble inserted. rst_n low mid-run → next cycle all fwd 0, stall 0, hazard_cnt 0. Preload hazard_cnt to 0xFFFF and force a hazard → it stays 0xFFFF.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and helpers for the hazard scoreboard: slot record, forward
// encoding and the parameter legality check used at elaboration.
package hazard_pkg;

  // Widest register index a slot can hold; narrower indices are zero-extended.
  localparam int RD_MAX_W = 8;

  localparam int FWD_RF = 0;

  typedef struct packed {
    logic                valid;
    logic [RD_MAX_W-1:0] rd;
    logic                is_load;
  } slot_t;

  localparam int    SLOT_W      = $bits(slot_t);
  localparam slot_t SLOT_BUBBLE = '0;

  function automatic bit ready_order_ok(input int alu_ready, input int load_ready,
                                        input int depth, input int rw);
    return (alu_ready >= 1) && (alu_ready <= load_ready) &&
           (load_ready <= depth) && (rw <= RD_MAX_W);
  endfunction

  // A bubble or register x0 never matches, nor does an operand that is not read.
  function automatic logic slot_matches(input slot_t s, input logic [RD_MAX_W-1:0] r,
                                        input logic used);
    return used && s.valid && (s.rd == r) && (r != '0);
  endfunction

endpackage

// File: rtl/hazard_slot_pipe.sv
// Shift register of in-flight destinations: slot 1 (index 0) is EX, the last
// slot is WB. Advances when not frozen, inserting either the issued entry or a bubble.
module hazard_slot_pipe
  import hazard_pkg::*;
#(
  parameter int RW         = 5,
  parameter int PIPE_DEPTH = 3
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         advance,
  input  logic                         insert,
  input  logic [RW-1:0]                in_rd,
  input  logic                         in_is_load,
  output logic [PIPE_DEPTH*SLOT_W-1:0] slots_flat
);

  slot_t slots [PIPE_DEPTH];
  slot_t entry;

  always_comb begin
    entry = SLOT_BUBBLE;
    if (insert) begin
      entry.valid   = 1'b1;
      entry.rd      = RD_MAX_W'(in_rd);
      entry.is_load = in_is_load;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < PIPE_DEPTH; k++) slots[k] <= SLOT_BUBBLE;
    end else if (advance) begin
      slots[0] <= entry;
      for (int k = 1; k < PIPE_DEPTH; k++) slots[k] <= slots[k-1];
    end
  end

  always_comb begin
    slots_flat = '0;
    for (int k = 0; k < PIPE_DEPTH; k++) slots_flat[k*SLOT_W +: SLOT_W] = slots[k];
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// ID-stage hazard scoreboard: picks the youngest in-flight producer per source,
// decides stall vs forward by result class, and counts data-hazard stall cycles.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int NREG       = 32,
  parameter int PIPE_DEPTH = 3,
  parameter int ALU_READY  = 1,
  parameter int LOAD_READY = 2,
  parameter int CNT_W      = 16,
  localparam int RW        = $clog2(NREG),
  localparam int FW        = $clog2(PIPE_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             issue_valid,
  input  logic [RW-1:0]    issue_rd,
  input  logic             issue_is_load,
  input  logic [RW-1:0]    issue_rs1,
  input  logic [RW-1:0]    issue_rs2,
  input  logic             use_rs1,
  input  logic             use_rs2,
  input  logic             flush,
  input  logic             mem_stall,
  output logic             stall,
  output logic [FW-1:0]    fwd_rs1,
  output logic [FW-1:0]    fwd_rs2,
  output logic [CNT_W-1:0] hazard_cnt
);

  if (!ready_order_ok(ALU_READY, LOAD_READY, PIPE_DEPTH, RW)) begin : g_bad_params
    $error("hazard_scoreboard: need 1 <= ALU_READY <= LOAD_READY <= PIPE_DEPTH");
  end

  localparam logic [FW-1:0] ALU_AT  = FW'(ALU_READY);
  localparam logic [FW-1:0] LOAD_AT = FW'(LOAD_READY);

  logic [PIPE_DEPTH*SLOT_W-1:0] slots_flat;
  slot_t                        slot [PIPE_DEPTH];
  logic                         hit1, hit2, load1, load2, early1, early2;
  logic [FW-1:0]                pos1, pos2;
  logic                         data_hazard, accept;

  always_comb begin
    for (int k = 0; k < PIPE_DEPTH; k++) slot[k] = slot_t'(slots_flat[k*SLOT_W +: SLOT_W]);
  end

  // Scan oldest to youngest so the youngest match overwrites any older one.
  always_comb begin
    hit1  = 1'b0;
    pos1  = '0;
    load1 = 1'b0;
    hit2  = 1'b0;
    pos2  = '0;
    load2 = 1'b0;
    for (int k = PIPE_DEPTH; k >= 1; k--) begin
      if (slot_matches(slot[k-1], RD_MAX_W'(issue_rs1), use_rs1)) begin
        hit1  = 1'b1;
        pos1  = FW'(k);
        load1 = slot[k-1].is_load;
      end
      if (slot_matches(slot[k-1], RD_MAX_W'(issue_rs2), use_rs2)) begin
        hit2  = 1'b1;
        pos2  = FW'(k);
        load2 = slot[k-1].is_load;
      end
    end
  end

  always_comb begin
    early1      = hit1 && (pos1 < (load1 ? LOAD_AT : ALU_AT));
    early2      = hit2 && (pos2 < (load2 ? LOAD_AT : ALU_AT));
    fwd_rs1     = (hit1 && !early1) ? pos1 : FW'(FWD_RF);
    fwd_rs2     = (hit2 && !early2) ? pos2 : FW'(FWD_RF);
    data_hazard = issue_valid && !flush && (early1 || early2);
    stall       = mem_stall || data_hazard;
    accept      = issue_valid && !flush && !data_hazard;
  end

  hazard_slot_pipe #(
    .RW        (RW),
    .PIPE_DEPTH(PIPE_DEPTH)
  ) u_slot_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .advance   (!mem_stall),
    .insert    (accept),
    .in_rd     (issue_rd),
    .in_is_load(issue_is_load),
    .slots_flat(slots_flat)
  );

  // Only cycles lost to data hazards count; memory wait states are excluded.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hazard_cnt <= '0;
    end else if (data_hazard && !mem_stall && (hazard_cnt != '1)) begin
      hazard_cnt <= hazard_cnt + CNT_W'(1);
    end
  end

endmodule
